// File: rtl/ipml_pkt_prefetch_fifo.sv
// Packet prefetch FIFO: wide words in, narrow lanes out, first-word-fall-through.
// Storage is a registered-read RAM feeding a one-word read stage and an output
// word register with a lane counter. Frames whose final word is partial carry
// last/lanes so only the valid lanes are presented.
module ipml_pkt_prefetch_fifo #(
    parameter int WR_DATA_WIDTH = 32,
    parameter int RD_DATA_WIDTH = 8,
    parameter int RATIO         = 4,
    parameter int DEPTH_WIDTH   = 10,
    parameter bit MSB_FIRST     = 1'b1,
    parameter int AFULL_THRESH  = (1 << DEPTH_WIDTH) - 4,
    parameter int LW            = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WR_DATA_WIDTH-1:0] wr_data,
    input  logic                     wr_last,
    input  logic [LW-1:0]            wr_lanes,
    output logic                     wr_vld,
    input  logic                     rd_en,
    output logic                     rd_vld,
    output logic [RD_DATA_WIDTH-1:0] rd_data,
    output logic                     rd_last,
    output logic [DEPTH_WIDTH:0]     level,
    output logic                     almost_full,
    output logic                     overflow
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam int EW    = 1 + LW + WR_DATA_WIDTH;

    typedef logic [DEPTH_WIDTH:0] ptr_t;

    logic [EW-1:0] mem [DEPTH];

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t level_q, level_d;
    logic wr_vld_q, wr_vld_d;
    logic ovf_q, ovf_d;

    // read stage (RAM output register)
    logic          s1_vld_q, s1_vld_d;
    logic [EW-1:0] s1_q;

    // output word register
    logic                     out_vld_q, out_vld_d;
    logic [WR_DATA_WIDTH-1:0] out_data_q;
    logic                     out_last_q;
    logic [LW-1:0]            out_lanes_q;
    logic [LW-1:0]            lane_q, lane_d;

    logic wr_acc, fin_lane, retire, out_load, mem_rd;

    assign wr_acc   = wr_en & wr_vld_q;
    // final lane: lane RATIO-1, or the recorded lane count on a frame-end word
    assign fin_lane = (RATIO == 1) ||
                      (lane_q == (out_last_q ? out_lanes_q : LW'(RATIO - 1)));
    assign retire   = out_vld_q & rd_en & fin_lane;
    // output register takes the staged word when empty or retiring its word
    assign out_load = s1_vld_q & (~out_vld_q | retire);
    // RAM is read whenever the stage will be free next cycle; this keeps
    // words flowing back to back with no bubble at word boundaries
    assign mem_rd   = (rd_ptr_q != wr_ptr_q) & (~s1_vld_q | out_load);

    // next-state for pointers, level, flags and the prefetch pipeline
    always_comb begin
        wr_ptr_d  = wr_ptr_q + ptr_t'(wr_acc);
        rd_ptr_d  = rd_ptr_q + ptr_t'(mem_rd);
        level_d   = level_q + ptr_t'(wr_acc) - ptr_t'(retire);
        // level never exceeds DEPTH, so its MSB alone marks "full"
        wr_vld_d  = ~level_d[DEPTH_WIDTH];
        ovf_d     = ovf_q | (wr_en & ~wr_vld_q);
        s1_vld_d  = s1_vld_q;
        out_vld_d = out_vld_q;
        lane_d    = lane_q;
        if (mem_rd)
            s1_vld_d = 1'b1;
        else if (out_load)
            s1_vld_d = 1'b0;
        if (out_load) begin
            out_vld_d = 1'b1;
            lane_d    = '0;
        end else if (retire) begin
            out_vld_d = 1'b0;
            lane_d    = '0;
        end else if (out_vld_q && rd_en) begin
            lane_d    = lane_q + LW'(1);
        end
    end

    // storage write and registered read; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr_q[DEPTH_WIDTH-1:0]] <= {wr_last, wr_lanes, wr_data};
        if (mem_rd)
            s1_q <= mem[rd_ptr_q[DEPTH_WIDTH-1:0]];
    end

    // control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            wr_vld_q  <= 1'b1;
            ovf_q     <= 1'b0;
            s1_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
            lane_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            wr_vld_q  <= wr_vld_d;
            ovf_q     <= ovf_d;
            s1_vld_q  <= s1_vld_d;
            out_vld_q <= out_vld_d;
            lane_q    <= lane_d;
        end
    end

    // output word register; cleared so rd_data reads zero after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_lanes_q <= '0;
        end else if (out_load) begin
            {out_last_q, out_lanes_q, out_data_q} <= s1_q;
        end
    end

    // lane select
    if (RATIO == 1) begin : g_single
        assign rd_data = out_data_q[RD_DATA_WIDTH-1:0];
    end else begin : g_multi
        logic [RD_DATA_WIDTH-1:0] lanes [RATIO];
        for (genvar i = 0; i < RATIO; i++) begin : g_lane
            if (MSB_FIRST) begin : g_msb
                assign lanes[i] = out_data_q[WR_DATA_WIDTH-1-i*RD_DATA_WIDTH -: RD_DATA_WIDTH];
            end else begin : g_lsb
                assign lanes[i] = out_data_q[i*RD_DATA_WIDTH +: RD_DATA_WIDTH];
            end
        end
        assign rd_data = lanes[lane_q];
    end

    assign wr_vld      = wr_vld_q;
    assign rd_vld      = out_vld_q;
    assign rd_last     = out_vld_q & out_last_q & fin_lane;
    assign level       = level_q;
    assign almost_full = (level_q >= (DEPTH_WIDTH + 1)'(AFULL_THRESH));
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_ipml_pkt_prefetch_fifo.sv
// Directed plus random-traffic bench for ipml_pkt_prefetch_fifo (DEPTH_WIDTH=4).
// A lane scoreboard is filled on each accepted write and drained on each
// consumed lane; a small level/overflow model is checked every cycle.
module tb_ipml_pkt_prefetch_fifo;

    localparam int DEPTH = 16;
    localparam int AFT   = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_last = 1'b0;
    logic [1:0]  wr_lanes = '0;
    logic        rd_en = 1'b0;
    logic        wr_vld, rd_vld, rd_last, almost_full, overflow;
    logic [7:0]  rd_data;
    logic [4:0]  level;

    ipml_pkt_prefetch_fifo #(
        .WR_DATA_WIDTH(32), .RD_DATA_WIDTH(8), .RATIO(4),
        .DEPTH_WIDTH(4), .MSB_FIRST(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last), .wr_lanes(wr_lanes),
        .wr_vld(wr_vld),
        .rd_en(rd_en), .rd_vld(rd_vld), .rd_data(rd_data), .rd_last(rd_last),
        .level(level), .almost_full(almost_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       eow;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   mlev  = 0;
    logic movf  = 1'b0;
    int   words = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // expand one accepted word into its expected lanes, MSB lane first
    task automatic push(input logic [31:0] w, input logic lst, input logic [1:0] ln);
        int n;
        exp_t e;
        n = lst ? int'(ln) + 1 : 4;
        for (int i = 0; i < n; i++) begin
            e.d   = w[31-8*i -: 8];
            e.l   = lst && (i == n - 1);
            e.eow = (i == n - 1);
            sb.push_back(e);
        end
    endtask

    // one clock: score the consumed lane, model the write, then check state
    task automatic tick();
        logic acc, ret;
        exp_t e;
        acc = wr_en && (mlev < DEPTH);
        if (wr_en && mlev >= DEPTH) movf = 1'b1;
        ret = 1'b0;
        if (rd_en && rd_vld) begin
            chk("sb_has_lane", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rd_data", 32'(rd_data), 32'(e.d));
                chk("rd_last", 32'(rd_last), 32'(e.l));
                ret = e.eow;
            end
        end
        if (acc) push(wr_data, wr_last, wr_lanes);
        mlev = mlev + int'(acc) - int'(ret);
        @(posedge clk);
        #1;
        chk("level",  32'(level),       32'(mlev));
        chk("wr_vld", 32'(wr_vld),      32'(mlev < DEPTH));
        chk("afull",  32'(almost_full), 32'(mlev >= AFT));
        chk("ovf",    32'(overflow),    32'(movf));
    endtask

    task automatic drain();
        rd_en = 1'b1;
        for (int c = 0; c < 400 && sb.size() > 0; c++) tick();
        chk("drain_empty", 32'(sb.size()), 32'd0);
        tick();
        chk("drain_rd_vld", 32'(rd_vld), 32'd0);
        rd_en = 1'b0;
    endtask

    initial begin
        // reset, then idle reads do nothing
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_vld", 32'(rd_vld), 32'd0);
        chk("rst_wr_vld", 32'(wr_vld), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_rd_last", 32'(rd_last), 32'd0);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_rd_vld", 32'(rd_vld), 32'd0);
        end
        rd_en = 1'b0;

        // two-word frame: latency 2, then 8 bubble-free lanes
        wr_en = 1'b1; wr_data = 32'hAABBCCDD; wr_last = 1'b0; wr_lanes = 2'd0;
        tick();
        chk("lat_edge1", 32'(rd_vld), 32'd0);
        wr_data = 32'h11223344; wr_last = 1'b1; wr_lanes = 2'd3;
        tick();
        wr_en = 1'b0;
        chk("lat_edge2", 32'(rd_vld), 32'd0);
        tick();
        chk("lat_edge3", 32'(rd_vld), 32'd1);
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("stream_vld", 32'(rd_vld), 32'd1);
            tick();
        end
        chk("stream_sb", 32'(sb.size()), 32'd0);
        chk("stream_done", 32'(rd_vld), 32'd0);
        rd_en = 1'b0;

        // partial final word: two lanes only
        wr_en = 1'b1; wr_data = 32'h55667788; wr_last = 1'b1; wr_lanes = 2'd1;
        tick();
        wr_en = 1'b0;
        tick();
        tick();
        chk("part_vld", 32'(rd_vld), 32'd1);
        rd_en = 1'b1;
        tick();
        tick();
        chk("part_sb", 32'(sb.size()), 32'd0);
        chk("part_no_extra", 32'(rd_vld), 32'd0);
        tick();
        chk("part_still_empty", 32'(rd_vld), 32'd0);
        rd_en = 1'b0;

        // fill to capacity, then one write too many
        wr_en = 1'b1; wr_last = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_data = 32'hC0DE0000 + 32'(i);
            tick();
            if (i == 11) chk("afull_at12", 32'(almost_full), 32'd1);
        end
        chk("full_wr_vld", 32'(wr_vld), 32'd0);
        chk("full_level", 32'(level), 32'd16);
        wr_data = 32'hDEADBEEF;
        tick();
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(level), 32'd16);
        wr_en = 1'b0;

        // retire one word, then write while retiring at level 15
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("lvl15", 32'(level), 32'd15);
        for (int i = 0; i < 3; i++) tick();
        wr_en = 1'b1; wr_data = 32'h0BADF00D;
        tick();
        chk("simul_level", 32'(level), 32'd15);
        wr_en = 1'b0;

        // random traffic across many pointer wraps
        words = 0;
        for (int c = 0; c < 20000 && words < 1000; c++) begin
            wr_en    = ($urandom_range(0, 3) != 0);
            wr_data  = $urandom;
            wr_last  = 1'($urandom_range(0, 1));
            wr_lanes = 2'($urandom_range(0, 3));
            rd_en    = ($urandom_range(0, 3) != 0);
            if (wr_en && mlev < DEPTH) words++;
            tick();
        end
        chk("traffic_words", 32'(words), 32'd1000);
        wr_en = 1'b0;
        drain();

        // reset after two of four lanes are read
        wr_en = 1'b1; wr_data = 32'hA0B0C0D0; wr_last = 1'b0;
        tick();
        wr_en = 1'b0;
        tick();
        tick();
        rd_en = 1'b1;
        tick();
        tick();
        rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_vld", 32'(rd_vld), 32'd0);
        chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
        chk("mid_rst_rd_last", 32'(rd_last), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_wr_vld", 32'(wr_vld), 32'd1);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        sb.delete();
        mlev = 0;
        movf = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_en = 1'b1; wr_data = 32'h01020304; wr_last = 1'b0;
        tick();
        wr_en = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
